valve_sequencer: RTL and testbench

Parametrised pneumatic controller for an array of `valve` cells. It accepts one command at a time over a valid/ready handshake and drives the `air_in` lines of `NUM_VALVES` valves. Supported commands are static set, timed pulse and 3-valve peristaltic pumping; every command ends with a settle window that covers membrane actuation time, then a done pulse. It sits between the off-chip solenoid bank and the valve/interconnect arrays.

---
 rtl/valve_sequencer.sv | 176 +++++++++++++++++
 tb/tb_valve_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/valve_sequencer.sv
// Purpose : sequences pneumatic air lines for a valve array (static set, timed pulse, 3-valve peristaltic pump).
// Latency : air_out changes 1 cycle after accept; done 1+active+SETTLE_CYCLES cycles after accept.
// Backpr. : one command at a time; cmd_ready is high only in IDLE, rejected commands leave it high.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (accept when both high)
//   cmd_mode                 0=SET, 1=PULSE, 2=PUMP, 3=reserved (rejected)
//   cmd_mask                 SET pattern / PULSE toggle mask (1 = pressurised, valve closed)
//   cmd_period, cmd_count    cycles per pulse or pump phase; number of full pump cycles
//   abort                    force all lines closed, then settle and report
//   air_out                  registered drive to the valve air_in lines
//   busy, done, aborted, err status; done/aborted/err are one-cycle pulses
module valve_sequencer #(
   parameter int NUM_VALVES    = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_mode,
   input  logic [NUM_VALVES-1:0] cmd_mask,
   input  logic [CNT_W-1:0]      cmd_period,
   input  logic [CNT_W-1:0]      cmd_count,
   input  logic                  abort,
   output logic [NUM_VALVES-1:0] air_out,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  err
);

   localparam logic [1:0] MODE_SET   = 2'd0;
   localparam logic [1:0] MODE_PULSE = 2'd1;
   localparam logic [1:0] MODE_PUMP  = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

   localparam int                SET_W       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {IDLE, PULSE, PUMP, SETTLE} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        per_cnt;     // cycles left in current pulse / pump phase
   logic [CNT_W-1:0]        per_val;     // pump phase length, reloaded each phase
   logic [CNT_W-1:0]        cyc_cnt;     // full pump cycles left, including the current one
   logic [2:0]              phase;       // pump phase index 0..5
   logic [SET_W-1:0]        settle_cnt;
   logic [NUM_VALVES-1:0]   saved;       // air_out before a pulse, restored afterwards
   logic                    abort_pend;  // current settle window was entered by abort
   logic                    reject;

   // Peristaltic pattern on bits [2:0]: exactly one valve opens or closes per phase.
   function automatic logic [2:0] pump_pat(input logic [2:0] ph);
      case (ph)
         3'd0:    pump_pat = 3'b101;
         3'd1:    pump_pat = 3'b100;
         3'd2:    pump_pat = 3'b110;
         3'd3:    pump_pat = 3'b010;
         3'd4:    pump_pat = 3'b011;
         default: pump_pat = 3'b001;
      endcase
   endfunction

   // Zero-length loads are refused up front so the counters never wrap.
   assign reject = (cmd_mode == MODE_RSVD) ||
                   ((cmd_mode == MODE_PULSE) && (cmd_period == '0)) ||
                   ((cmd_mode == MODE_PUMP) && ((cmd_period == '0) || (cmd_count == '0)));

   assign busy = ~cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         air_out    <= '1;
         cmd_ready  <= 1'b1;
         done       <= 1'b0;
         aborted    <= 1'b0;
         err        <= 1'b0;
         per_cnt    <= '0;
         per_val    <= '0;
         cyc_cnt    <= '0;
         phase      <= '0;
         settle_cnt <= '0;
         saved      <= '1;
         abort_pend <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         err     <= 1'b0;
         if ((state != IDLE) && abort) begin
            // Safe state: every valve closed, settle window restarted.
            air_out    <= '1;
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
            abort_pend <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     if (reject) begin
                        err <= 1'b1;
                     end else begin
                        cmd_ready <= 1'b0;
                        case (cmd_mode)
                           MODE_SET: begin
                              air_out    <= cmd_mask;
                              state      <= SETTLE;
                              settle_cnt <= SETTLE_LOAD;
                           end
                           MODE_PULSE: begin
                              saved   <= air_out;
                              air_out <= air_out ^ cmd_mask;
                              per_cnt <= cmd_period;
                              state   <= PULSE;
                           end
                           default: begin
                              air_out[2:0] <= pump_pat(3'd0);
                              phase        <= 3'd0;
                              per_cnt      <= cmd_period;
                              per_val      <= cmd_period;
                              cyc_cnt      <= cmd_count;
                              state        <= PUMP;
                           end
                        endcase
                     end
                  end
               end
               PULSE: begin
                  if (per_cnt == CNT_W'(1)) begin
                     air_out    <= saved;
                     state      <= SETTLE;
                     settle_cnt <= SETTLE_LOAD;
                  end else begin
                     per_cnt <= per_cnt - CNT_W'(1);
                  end
               end
               PUMP: begin
                  if (per_cnt != CNT_W'(1)) begin
                     per_cnt <= per_cnt - CNT_W'(1);
                  end else if (phase != 3'd5) begin
                     phase        <= phase + 3'd1;
                     air_out[2:0] <= pump_pat(phase + 3'd1);
                     per_cnt      <= per_val;
                  end else if (cyc_cnt != CNT_W'(1)) begin
                     cyc_cnt      <= cyc_cnt - CNT_W'(1);
                     phase        <= 3'd0;
                     air_out[2:0] <= pump_pat(3'd0);
                     per_cnt      <= per_val;
                  end else begin
                     // Last phase of last cycle: leave the pump valves open.
                     air_out[2:0] <= 3'b000;
                     state        <= SETTLE;
                     settle_cnt   <= SETTLE_LOAD;
                  end
               end
               SETTLE: begin
                  if (settle_cnt == SET_W'(1)) begin
                     state      <= IDLE;
                     cmd_ready  <= 1'b1;
                     done       <= 1'b1;
                     aborted    <= abort_pend;
                     abort_pend <= 1'b0;
                  end else begin
                     settle_cnt <= settle_cnt - SET_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_valve_sequencer.sv
// Purpose : self-checking bench for valve_sequencer (command table + abort/reset sequences).
// Latency : expected per-cycle outputs are queued when a command is driven, popped each negedge.
// Backpr. : next command is driven only after the previous expected trace has drained.
module tb_valve_sequencer;

   localparam int NV = 8;
   localparam int S  = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = '0;
   logic [NV-1:0] cmd_mask = '0;
   logic [CW-1:0] cmd_period = '0;
   logic [CW-1:0] cmd_count = '0;
   logic          abort = 1'b0;
   logic [NV-1:0] air_out;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          err;

   valve_sequencer #(.NUM_VALVES(NV), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_mask(cmd_mask),
      .cmd_period(cmd_period), .cmd_count(cmd_count),
      .abort(abort), .air_out(air_out), .busy(busy),
      .done(done), .aborted(aborted), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NV-1:0] air;
      logic rdy, bsy, dn, ab, er;
   } obs_t;

   typedef struct {
      obs_t o;
      int   id;
      int   cyc;
   } exp_t;

   typedef struct {
      logic [1:0]    mode;
      logic [NV-1:0] mask;
      logic [CW-1:0] period;
      logic [CW-1:0] count;
      logic          exp_err;
      logic [NV-1:0] exp_air1;     // value at T+1 (upper bits for PUMP)
      logic [NV-1:0] exp_air_end;  // value during settle
      int            exp_done;     // done offset from T, 0 for rejected
   } vec_t;

   exp_t       sb[$];
   vec_t       vec[10];
   logic [2:0] pat[6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
   int         errors = 0;
   int         checks = 0;
   exp_t       mon_e;
   obs_t       mon_got;

   always @(negedge clk) begin
      if (!rst && sb.size() > 0) begin
         mon_e       = sb.pop_front();
         mon_got.air = air_out;
         mon_got.rdy = cmd_ready;
         mon_got.bsy = busy;
         mon_got.dn  = done;
         mon_got.ab  = aborted;
         mon_got.er  = err;
         checks++;
         if (mon_got !== mon_e.o) begin
            errors++;
            $display("FAIL sb id=%0d T+%0d got air=%h rdy=%b busy=%b done=%b abrt=%b err=%b want air=%h rdy=%b busy=%b done=%b abrt=%b err=%b",
                     mon_e.id, mon_e.cyc, mon_got.air, mon_got.rdy, mon_got.bsy, mon_got.dn, mon_got.ab, mon_got.er,
                     mon_e.o.air, mon_e.o.rdy, mon_e.o.bsy, mon_e.o.dn, mon_e.o.ab, mon_e.o.er);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic push(input int id, input int cyc, input logic [NV-1:0] a,
                       input logic r, input logic d, input logic ab, input logic er);
      exp_t e;
      e.o.air = a;
      e.o.rdy = r;
      e.o.bsy = ~r;
      e.o.dn  = d;
      e.o.ab  = ab;
      e.o.er  = er;
      e.id    = id;
      e.cyc   = cyc;
      sb.push_back(e);
   endtask

   task automatic build_trace(input int id, input vec_t v);
      int            act;
      logic [NV-1:0] a;
      if (v.exp_err) begin
         push(id, 1, v.exp_air1, 1'b1, 1'b0, 1'b0, 1'b1);
         for (int c = 2; c <= 4; c++) push(id, c, v.exp_air1, 1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
         act = v.exp_done - S - 1;
         for (int c = 1; c <= v.exp_done + 1; c++) begin
            if (c <= act && v.mode == 2'd2)
               a = {v.exp_air1[NV-1:3], pat[((c - 1) / int'(v.period)) % 6]};
            else if (c <= act)
               a = v.exp_air1;
            else
               a = v.exp_air_end;
            push(id, c, a, (c >= v.exp_done), (c == v.exp_done), 1'b0, 1'b0);
         end
      end
   endtask

   task automatic drive(input logic [1:0] m, input logic [NV-1:0] mk,
                        input logic [CW-1:0] p, input logic [CW-1:0] n);
      @(posedge clk);
      #1;
      cmd_valid  = 1'b1;
      cmd_mode   = m;
      cmd_mask   = mk;
      cmd_period = p;
      cmd_count  = n;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout left=%0d want=0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int dcount;

      vec[0] = '{2'd0, 8'hA5, 16'd0, 16'd0, 1'b0, 8'hA5, 8'hA5, S + 1};
      vec[1] = '{2'd1, 8'h0F, 16'd3, 16'd0, 1'b0, 8'hAA, 8'hA5, 3 + S + 1};
      vec[2] = '{2'd0, 8'hF0, 16'd0, 16'd0, 1'b0, 8'hF0, 8'hF0, S + 1};
      vec[3] = '{2'd2, 8'h00, 16'd2, 16'd1, 1'b0, 8'hF5, 8'hF0, 12 + S + 1};
      vec[4] = '{2'd3, 8'h00, 16'd5, 16'd5, 1'b1, 8'hF0, 8'hF0, 0};
      vec[5] = '{2'd2, 8'h00, 16'd2, 16'd0, 1'b1, 8'hF0, 8'hF0, 0};
      vec[6] = '{2'd1, 8'hFF, 16'd0, 16'd0, 1'b1, 8'hF0, 8'hF0, 0};
      vec[7] = '{2'd1, 8'hFF, 16'd1, 16'd0, 1'b0, 8'h0F, 8'hF0, 1 + S + 1};
      vec[8] = '{2'd2, 8'h00, 16'd1, 16'd2, 1'b0, 8'hF5, 8'hF0, 12 + S + 1};
      vec[9] = '{2'd0, 8'h00, 16'd0, 16'd0, 1'b0, 8'h00, 8'h00, S + 1};

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_air", 32'(air_out), 32'hFF);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Command table
      for (int i = 0; i < 10; i++) begin
         drive(vec[i].mode, vec[i].mask, vec[i].period, vec[i].count);
         @(negedge clk);
         #1 build_trace(i, vec[i]);
         @(posedge clk);
         #1 cmd_valid = 1'b0;
         wait_empty("vec");
      end

      // Abort at T+5 of a PUMP (starting from 0x00)
      drive(2'd2, 8'h00, 16'd2, 16'd3);
      @(negedge clk);
      #1;
      push(20, 1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      push(20, 2, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
      push(20, 3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
      push(20, 4, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
      push(20, 5, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 6; c <= 21; c++) push(20, c, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      push(20, 22, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      push(20, 23, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_empty("abort");

      // Abort coincident with an accepted command in IDLE: command wins
      drive(2'd0, 8'h3C, 16'd0, 16'd0);
      abort = 1'b1;
      @(negedge clk);
      #1;
      for (int c = 1; c <= S; c++) push(21, c, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      push(21, S + 1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
      push(21, S + 2, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      wait_empty("idle_abort");

      // Reset in the middle of a PUMP (from 0x3C)
      drive(2'd2, 8'h00, 16'd3, 16'd2);
      @(negedge clk);
      #1;
      push(30, 1, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b0);
      push(30, 2, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b0);
      push(30, 3, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b0);
      push(30, 4, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      wait_empty("pump_pre_rst");
      #2 rst = 1'b1;
      #1;
      check("midrst_air", 32'(air_out), 32'hFF);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      dcount = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("midrst_no_done", 32'(dcount), 32'd0);
      check("midrst_air_hold", 32'(air_out), 32'hFF);
      check("midrst_ready_hold", 32'(cmd_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
